rambus_wide: RTL and testbench



---
 rtl/gf180mcu_fd_ip_sram__sram512x8m8wm1.sv | 36 +++
 rtl/rambus_wide.sv | 126 ++++++++++++
 tb/tb_rambus_wide.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_ip_sram__sram512x8m8wm1.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_ip_sram__sram512x8m8wm1
//  Brief    : Behavioural model of the 512x8 single-port SRAM macro with
//             active-low enables and a per-bit write mask. Q updates only on
//             an enabled read and holds its value otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
    input  logic       CLK,
    input  logic       CEN,
    input  logic       GWEN,
    input  logic [7:0] WEN,
    input  logic [8:0] A,
    input  logic [7:0] D,
    output logic [7:0] Q
);

    logic [7:0] r_mem [512];
    logic [7:0] r_q;

    // Enabled access: masked bit write when GWEN is low, otherwise a read into Q
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
            end else begin
                r_q <= r_mem[A];
            end
        end
    end

    assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/rambus_wide.sv
`default_nettype none
// ============================================================================
//  Module   : rambus_wide
//  Brief    : Wishbone-classic slave over BANKS x 4 SRAM macros giving a
//             32-bit byte-maskable RAM of 512*BANKS words. Single-cycle
//             accept, one-cycle ack, optional registered read data.
//  Revision : 1.0  initial release
// ============================================================================
module rambus_wide #(
    parameter int BANKS    = 1,
    parameter int ADDR_W   = 9 + $clog2(BANKS),
    parameter int READ_REG = 0
) (
    input  logic              rambus_wb_clk_i,
    input  logic              rambus_wb_rst_ni,
    input  logic              rambus_wb_stb_i,
    input  logic              rambus_wb_cyc_i,
    input  logic              rambus_wb_we_i,
    input  logic [3:0]        rambus_wb_sel_i,
    input  logic [31:0]       rambus_wb_dat_i,
    input  logic [ADDR_W-1:0] rambus_wb_addr_i,
    output logic              rambus_wb_ack_o,
    output logic [31:0]       rambus_wb_dat_o
);

    localparam int C_BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RDREG = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ack;
    logic [31:0]         r_data;
    logic [C_BANK_W-1:0] r_bank;

    logic                w_accept;
    logic [C_BANK_W-1:0] w_bank;
    logic [31:0]         w_q [BANKS];
    logic [31:0]         w_rdata;
    logic [4*BANKS-1:0]  w_cen_n;

    // Accept only from IDLE and never while reset is asserted, so no macro
    // is touched during reset.
    assign w_accept = (r_state == S_IDLE) && rambus_wb_cyc_i && rambus_wb_stb_i
                      && rambus_wb_rst_ni;

    if (BANKS > 1) begin : g_bank_multi
        assign w_bank = rambus_wb_addr_i[ADDR_W-1:9];
    end else begin : g_bank_single
        assign w_bank = '0;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar n = 0; n < 4; n++) begin : g_lane
            assign w_cen_n[b*4+n] = !(w_accept && (w_bank == C_BANK_W'(b)));

            gf180mcu_fd_ip_sram__sram512x8m8wm1 u_sram (
                .CLK  (rambus_wb_clk_i),
                .CEN  (w_cen_n[b*4+n]),
                .GWEN (!(w_accept && rambus_wb_we_i)),
                .WEN  (w_accept ? {8{!rambus_wb_sel_i[n]}} : 8'hFF),
                .A    (rambus_wb_addr_i[8:0]),
                .D    (rambus_wb_dat_i[8*n+7:8*n]),
                .Q    (w_q[b][8*n+7:8*n])
            );
        end
    end

    // Bank whose macros were accessed in the accept cycle selects the read word
    assign w_rdata = w_q[r_bank];

    // Transaction FSM: accept in IDLE, optional read-capture cycle, one ack cycle
    always_ff @(posedge rambus_wb_clk_i) begin
        if (!rambus_wb_rst_ni) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_data  <= '0;
            r_bank  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack  <= 1'b0;
                    r_data <= '0;
                    if (w_accept) begin
                        r_bank <= w_bank;
                        if (rambus_wb_we_i || (READ_REG == 0)) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_RDREG;
                        end
                    end
                end
                S_RDREG: begin
                    // A dropped cycle abandons the read silently
                    if (!rambus_wb_cyc_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_data  <= w_rdata;
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_data  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_data  <= '0;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is asserted; data only shows during ack
    assign rambus_wb_ack_o = r_ack && rambus_wb_rst_ni;
    assign rambus_wb_dat_o = rambus_wb_ack_o ? ((READ_REG != 0) ? r_data : w_rdata) : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_rambus_wide.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rambus_wide
//  Brief    : Self-checking bench for rambus_wide. Two instances with
//             BANKS=2: dut0 uses direct read data, dut1 registered read data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rambus_wide;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        cyc0, cyc1;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [9:0]  addr;
    logic        ack0, ack1;
    logic [31:0] rdat0, rdat1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [9:0]  addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    rambus_wide #(.BANKS(2), .READ_REG(0)) dut0 (
        .rambus_wb_clk_i  (clk),
        .rambus_wb_rst_ni (rst_n),
        .rambus_wb_stb_i  (stb),
        .rambus_wb_cyc_i  (cyc0),
        .rambus_wb_we_i   (we),
        .rambus_wb_sel_i  (sel),
        .rambus_wb_dat_i  (wdat),
        .rambus_wb_addr_i (addr),
        .rambus_wb_ack_o  (ack0),
        .rambus_wb_dat_o  (rdat0)
    );

    rambus_wide #(.BANKS(2), .READ_REG(1)) dut1 (
        .rambus_wb_clk_i  (clk),
        .rambus_wb_rst_ni (rst_n),
        .rambus_wb_stb_i  (stb),
        .rambus_wb_cyc_i  (cyc1),
        .rambus_wb_we_i   (we),
        .rambus_wb_sel_i  (sel),
        .rambus_wb_dat_i  (wdat),
        .rambus_wb_addr_i (addr),
        .rambus_wb_ack_o  (ack1),
        .rambus_wb_dat_o  (rdat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One complete transaction on dut d, checking ack timing and read data
    task automatic xact(input int d, input logic w, input logic [3:0] s,
                        input logic [31:0] wd, input logic [9:0] a,
                        input logic [31:0] exp, input string nm);
        int lat;
        lat  = (d == 1 && !w) ? 2 : 1;
        we   = w;
        sel  = s;
        wdat = wd;
        addr = a;
        stb  = 1'b1;
        if (d == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
        #1;
        check({nm, " ack c0"}, 32'((d == 0) ? ack0 : ack1), 32'h0);
        for (int i = 1; i <= lat; i++) begin
            tick();
            if (i < lat) begin
                check({nm, " ack early"}, 32'((d == 0) ? ack0 : ack1), 32'h0);
                check({nm, " dat early"}, (d == 0) ? rdat0 : rdat1, 32'h0);
            end else begin
                check({nm, " ack"}, 32'((d == 0) ? ack0 : ack1), 32'h1);
                if (!w) check({nm, " rdata"}, (d == 0) ? rdat0 : rdat1, exp);
            end
        end
        cyc0 = 1'b0;
        cyc1 = 1'b0;
        stb  = 1'b0;
        tick();
        check({nm, " ack after"}, 32'((d == 0) ? ack0 : ack1), 32'h0);
        check({nm, " dat after"}, (d == 0) ? rdat0 : rdat1, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0;
        we = 1'b0; sel = 4'h0; wdat = 32'h0; addr = 10'h0;

        vecs[0]  = '{1'b0, 4'hF, 32'h0,        10'h020, 32'h55AA55AA};
        vecs[1]  = '{1'b1, 4'hF, 32'hDEADBEEF, 10'h005, 32'h0};
        vecs[2]  = '{1'b1, 4'hF, 32'h12345678, 10'h205, 32'h0};
        vecs[3]  = '{1'b0, 4'hF, 32'h0,        10'h005, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,        10'h205, 32'h12345678};
        vecs[5]  = '{1'b1, 4'hF, 32'h11223344, 10'h010, 32'h0};
        vecs[6]  = '{1'b1, 4'h5, 32'hAABBCCDD, 10'h010, 32'h0};
        vecs[7]  = '{1'b0, 4'hF, 32'h0,        10'h010, 32'h11BB33DD};
        vecs[8]  = '{1'b1, 4'h0, 32'hFFFFFFFF, 10'h010, 32'h0};
        vecs[9]  = '{1'b0, 4'hF, 32'h0,        10'h010, 32'h11BB33DD};
        vecs[10] = '{1'b1, 4'hF, 32'h00000000, 10'h3FF, 32'h0};
        vecs[11] = '{1'b1, 4'h8, 32'hA5FFFFFF, 10'h3FF, 32'h0};
        vecs[12] = '{1'b0, 4'h3, 32'h0,        10'h3FF, 32'hA5000000};

        // Reset held with an active request: nothing may happen
        tick();
        cyc0 = 1'b1; cyc1 = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        wdat = 32'h55AA55AA; addr = 10'h020;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst ack0", 32'(ack0), 32'h0);
            check("rst ack1", 32'(ack1), 32'h0);
            check("rst dat0", rdat0, 32'h0);
            check("rst cen0", 32'(dut0.w_cen_n), 32'hFF);
            check("rst cen1", 32'(dut1.w_cen_n), 32'hFF);
            tick();
        end
        rst_n = 1'b1;
        #1;
        check("rel cen0 bank0", 32'(dut0.w_cen_n), 32'hF0);
        check("rel ack0", 32'(ack0), 32'h0);
        tick();
        check("rel ack0 c1", 32'(ack0), 32'h1);
        check("rel ack1 c1", 32'(ack1), 32'h1);
        cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0;
        tick();
        check("rel ack0 c2", 32'(ack0), 32'h0);

        // Table-driven transactions on the direct-read instance
        for (int i = 0; i < 13; i++) begin
            xact(0, vecs[i].we, vecs[i].sel, vecs[i].wd, vecs[i].addr, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        // Back-to-back reads with cyc/stb held: ack must alternate
        we = 1'b0; sel = 4'hF; addr = 10'h005; cyc0 = 1'b1; stb = 1'b1;
        #1;
        check("b2b ack c0", 32'(ack0), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("b2b ack c%0d", i), 32'(ack0), (i % 2 == 1) ? 32'h1 : 32'h0);
            check($sformatf("b2b dat c%0d", i), rdat0, (i % 2 == 1) ? 32'hDEADBEEF : 32'h0);
            if (i == 8) begin
                cyc0 = 1'b0; stb = 1'b0;
            end
        end
        tick();
        check("b2b ack tail", 32'(ack0), 32'h0);

        // stb without cyc is ignored
        stb = 1'b1; we = 1'b1; addr = 10'h005; wdat = 32'h0;
        tick();
        tick();
        check("stb only ack", 32'(ack0), 32'h0);
        stb = 1'b0;
        tick();

        // Registered-read instance
        xact(1, 1'b1, 4'hF, 32'hCAFEF00D, 10'h105, 32'h0, "rr wr");
        xact(1, 1'b0, 4'hF, 32'h0,        10'h105, 32'hCAFEF00D, "rr rd");

        // Abort in RDREG, then a new request must be accepted straight away
        we = 1'b0; addr = 10'h105; cyc1 = 1'b1; stb = 1'b1;
        tick();
        check("abort ack c1", 32'(ack1), 32'h0);
        cyc1 = 1'b0;
        tick();
        check("abort ack c2", 32'(ack1), 32'h0);
        we = 1'b1; addr = 10'h106; wdat = 32'h0BADCAFE; cyc1 = 1'b1;
        tick();
        check("abort idle ack", 32'(ack1), 32'h1);
        cyc1 = 1'b0; stb = 1'b0;
        tick();
        check("abort ack tail", 32'(ack1), 32'h0);

        // Reset in the cycle after an accepted write: no ack, data retained
        we = 1'b1; sel = 4'hF; addr = 10'h107; wdat = 32'h1234ABCD; cyc1 = 1'b1; stb = 1'b1;
        tick();
        rst_n = 1'b0; cyc1 = 1'b0; stb = 1'b0;
        #1;
        check("midrst ack c1", 32'(ack1), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("midrst ack c2", 32'(ack1), 32'h0);
        tick();
        xact(1, 1'b0, 4'hF, 32'h0, 10'h107, 32'h1234ABCD, "midrst rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
